led_shift_ctrl: RTL and testbench

LED_SHIFT_CTRL -- requirements
Module: led_shift_ctrl

---
 rtl/led_shift_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_led_shift_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_shift_ctrl.sv
// rtl/led_shift_ctrl.sv - LED shift-pattern sequencer with rotate, ping-pong and fill/drain modes
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request: load seed (0 becomes 1) and begin sequencing
//   pause      level: while high, stepping is frozen (HOLD)
//   stop       one-cycle request: abort, clear led, return to IDLE
//   mode       00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill/drain
//   seed       initial pattern
//   led        registered pattern
//   busy       high in RUN or HOLD
//   step_tick  one-cycle pulse on each shift
//   wrap       one-cycle pulse at a sequence boundary, coincident with step_tick
//
// Configuration macro: LED_CTRL_PINGPONG_EN enables the ping-pong mode; without it
// there is no direction register and mode 10 behaves as rotate-left.
module led_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] led,
    output logic             busy,
    output logic             step_tick,
    output logic             wrap
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    presc;
    logic [WIDTH-1:0] ref_pat;
    logic             phase;        // 0: fill, 1: drain
    logic [WIDTH-1:0] led_nxt;
    logic             phase_nxt;
    logic             wrap_nxt;
    logic [WIDTH-1:0] seed_ld;
    logic [WIDTH-1:0] rot_l, rot_r, fill_pat, drain_pat;
    logic             counting, step_now;
`ifdef LED_CTRL_PINGPONG_EN
    logic             dir;          // 0: left, 1: right
    logic             dir_nxt;
    logic [WIDTH-1:0] shl, shr;
`endif

    assign busy     = (state != IDLE);
    assign seed_ld  = (seed == '0) ? ONE : seed;
    // The prescaler advances on every non-paused busy cycle, including the
    // HOLD->RUN edge, so a paused count resumes exactly where it froze.
    assign counting = busy && !stop && !pause;
    assign step_now = counting && (presc == PRESC_MAX);

    assign rot_l     = {led[WIDTH-2:0], led[WIDTH-1]};
    assign rot_r     = {led[0], led[WIDTH-1:1]};
    assign fill_pat  = {led[WIDTH-2:0], 1'b1};
    assign drain_pat = {led[WIDTH-2:0], 1'b0};
`ifdef LED_CTRL_PINGPONG_EN
    assign shl       = {led[WIDTH-2:0], 1'b0};
    assign shr       = {1'b0, led[WIDTH-1:1]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!stop && start) state_nxt = RUN;
            RUN:     if (stop) state_nxt = IDLE;
                     else if (pause) state_nxt = HOLD;
            HOLD:    if (stop) state_nxt = IDLE;
                     else if (!pause) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Next pattern for a step, chosen by the mode sampled in the step cycle.
    always_comb begin
        led_nxt   = led;
        phase_nxt = phase;
        wrap_nxt  = 1'b0;
`ifdef LED_CTRL_PINGPONG_EN
        dir_nxt   = dir;
`endif
        case (mode)
            2'b00: begin
                led_nxt  = rot_l;
                wrap_nxt = (rot_l == ref_pat);
            end
            2'b01: begin
                led_nxt  = rot_r;
                wrap_nxt = (rot_r == ref_pat);
            end
            2'b10: begin
`ifdef LED_CTRL_PINGPONG_EN
                if (led[WIDTH-1] && led[0]) begin
                    // Pinned at both ends: hold the pattern, just turn around.
                    dir_nxt  = !dir;
                    wrap_nxt = 1'b1;
                end else if (!dir && led[WIDTH-1]) begin
                    dir_nxt  = 1'b1;
                    led_nxt  = shr;
                    wrap_nxt = 1'b1;
                end else if (dir && led[0]) begin
                    dir_nxt  = 1'b0;
                    led_nxt  = shl;
                    wrap_nxt = 1'b1;
                end else begin
                    led_nxt  = dir ? shr : shl;
                end
`else
                led_nxt  = rot_l;
                wrap_nxt = (rot_l == ref_pat);
`endif
            end
            2'b11: begin
                if (!phase) begin
                    led_nxt = fill_pat;
                    if (&fill_pat) begin
                        phase_nxt = 1'b1;
                        wrap_nxt  = 1'b1;
                    end
                end else begin
                    led_nxt = drain_pat;
                    if (drain_pat == '0) begin
                        phase_nxt = 1'b0;
                        wrap_nxt  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led       <= '0;
            presc     <= '0;
            ref_pat   <= '0;
            phase     <= 1'b0;
            step_tick <= 1'b0;
            wrap      <= 1'b0;
`ifdef LED_CTRL_PINGPONG_EN
            dir       <= 1'b0;
`endif
        end else begin
            step_tick <= 1'b0;
            wrap      <= 1'b0;
            if (stop) begin
                led   <= '0;
                presc <= '0;
            end else if (state == IDLE) begin
                if (start) begin
                    led     <= seed_ld;
                    ref_pat <= seed_ld;
                    phase   <= 1'b0;
                    presc   <= '0;
`ifdef LED_CTRL_PINGPONG_EN
                    dir     <= 1'b0;
`endif
                end
            end else if (counting) begin
                if (step_now) begin
                    presc     <= '0;
                    led       <= led_nxt;
                    phase     <= phase_nxt;
                    step_tick <= 1'b1;
                    wrap      <= wrap_nxt;
`ifdef LED_CTRL_PINGPONG_EN
                    dir       <= dir_nxt;
`endif
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_shift_ctrl.sv
// tb/tb_led_shift_ctrl.sv - scoreboard bench for led_shift_ctrl against a behavioural model
module tb_led_shift_ctrl;

    localparam int W    = 4;
    localparam int DIV  = 4;
    localparam int FULL = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic         stop = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] seed = '0;
    logic [W-1:0] led;
    logic         busy;
    logic         step_tick;
    logic         wrap;

    led_shift_ctrl #(.WIDTH(W), .DIV(DIV)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .stop(stop),
        .mode(mode), .seed(seed), .led(led), .busy(busy),
        .step_tick(step_tick), .wrap(wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint t;
        int     led;
        int     w;
    } exp_t;

    exp_t   sb[$];
    int     obs[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_ticks = 0;
    longint last_step_t = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts non-paused busy cycles; every DIV of them
    // produces one step whose pattern is computed arithmetically.
    int m_run = 0, m_led = 0, m_ref = 0, m_cnt = 0, m_right = 0, m_drain = 0;

    task automatic model_step();
        int p, np, md, w, top, bot;
        exp_t e;
        p  = m_led;
        md = int'(mode);
        w  = 0;
        np = p;
`ifndef LED_CTRL_PINGPONG_EN
        if (md == 2) md = 0;
`endif
        case (md)
            0: begin np = (p * 2) % (FULL + 1) + p / HALF; w = int'(np == m_ref); end
            1: begin np = p / 2 + (p % 2) * HALF;          w = int'(np == m_ref); end
            2: begin
                top = int'(p >= HALF);
                bot = p % 2;
                if (top == 1 && bot == 1) begin
                    m_right = 1 - m_right; w = 1;
                end else if (m_right == 0 && top == 1) begin
                    m_right = 1; np = p / 2; w = 1;
                end else if (m_right == 1 && bot == 1) begin
                    m_right = 0; np = (p * 2) % (FULL + 1); w = 1;
                end else begin
                    np = (m_right == 1) ? p / 2 : (p * 2) % (FULL + 1);
                end
            end
            default: begin
                if (m_drain == 0) begin
                    np = (p * 2 + 1) % (FULL + 1);
                    if (np == FULL) begin m_drain = 1; w = 1; end
                end else begin
                    np = (p * 2) % (FULL + 1);
                    if (np == 0) begin m_drain = 0; w = 1; end
                end
            end
        endcase
        m_led = np;
        e.t = longint'($time); e.led = np; e.w = w;
        sb.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_led = 0; m_cnt = 0; m_ref = 0; m_right = 0; m_drain = 0;
        end else if (stop) begin
            m_run = 0; m_led = 0; m_cnt = 0;
        end else if (m_run == 0) begin
            if (start) begin
                m_run = 1;
                m_led = (seed == 0) ? 1 : int'(seed);
                m_ref = m_led;
                m_cnt = 0; m_right = 0; m_drain = 0;
            end
        end else if (!pause) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                model_step();
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a step.
    always @(negedge clk) begin
        exp_t e;
        if (step_tick) begin
            n_ticks++;
            last_step_t = longint'($time) - 5;
            obs.push_back(int'({wrap, led}));
            if (sb.size() == 0) begin
                check("unexpected_step_tick", int'(step_tick), 0);
            end else begin
                e = sb.pop_front();
                check("step_time", int'(longint'($time) - 5), int'(e.t));
                check("step_led", int'(led), e.led);
                check("step_wrap", int'(wrap), e.w);
            end
        end else begin
            check("wrap_without_tick", int'(wrap), 0);
            if (sb.size() > 0 && sb[0].t <= longint'($time) - 5) begin
                check("missed_step_tick", int'(step_tick), 1);
                void'(sb.pop_front());
            end
        end
        check("busy_track", int'(busy), m_run);
        check("led_track", int'(led), m_led);
    end

    logic [4:0] t00 [8] = '{5'h02, 5'h04, 5'h08, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00};
    logic [4:0] t01 [8] = '{5'h08, 5'h04, 5'h02, 5'h11, 5'h00, 5'h00, 5'h00, 5'h00};
`ifdef LED_CTRL_PINGPONG_EN
    logic [4:0] t10 [8] = '{5'h02, 5'h04, 5'h08, 5'h14, 5'h02, 5'h01, 5'h12, 5'h00};
`else
    logic [4:0] t10 [8] = '{5'h02, 5'h04, 5'h08, 5'h11, 5'h02, 5'h04, 5'h08, 5'h00};
`endif
    logic [4:0] t11 [8] = '{5'h03, 5'h07, 5'h1f, 5'h0e, 5'h0c, 5'h08, 5'h10, 5'h01};

    task automatic run_dir(input string nm, input logic [W-1:0] s, input logic [1:0] md,
                           input int n, input logic [4:0] tbl [8]);
        @(posedge clk); #1;
        seed = s; mode = md; pause = 1'b0; start = 1'b1;
        obs.delete();
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_load"}, int'(led), (s == 0) ? 1 : int'(s));
        repeat (n * DIV) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0;
        check({nm, "_steps"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++)
            check({nm, "_seq"}, obs[i], int'(tbl[i]));
        check({nm, "_stop_led"}, int'(led), 0);
        check({nm, "_stop_busy"}, int'(busy), 0);
    endtask

    initial begin
        logic [W-1:0] frozen;
        longint       t_rel;
        int           ticks0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_step_tick", int'(step_tick), 0);
        check("reset_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", int'(busy), 0);

        run_dir("rotl", 4'b0001, 2'b00, 4, t00);
        run_dir("rotr", 4'b0000, 2'b01, 4, t01);
        run_dir("pingpong", 4'b0001, 2'b10, 7, t10);
        run_dir("filldrain", 4'b0001, 2'b11, 8, t11);

        // Pause two cycles after a step for ten cycles.
        @(posedge clk); #1;
        seed = 4'b0001; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (DIV) @(posedge clk);
        repeat (2) @(posedge clk);
        #1 pause = 1'b1;
        frozen = led;
        ticks0 = n_ticks;
        repeat (10) @(posedge clk);
        #1;
        check("pause_led_frozen", int'(led), int'(frozen));
        check("pause_no_tick", n_ticks, ticks0);
        check("pause_busy", int'(busy), 1);
        pause = 1'b0;
        t_rel = longint'($time);
        repeat (2) @(posedge clk);
        #6;
        check("pause_resume_time", int'(last_step_t), int'(t_rel - 1 + 20));
        stop = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        stop = 1'b0; start = 1'b0;
        check("stop_over_start_led", int'(led), 0);
        check("stop_over_start_busy", int'(busy), 0);

        // Randomised segments with mode changes, pauses, stops and stray starts.
        repeat (30) begin
            @(posedge clk); #1;
            seed = W'($urandom); mode = 2'($urandom); pause = 1'b0; start = 1'b1;
            repeat ($urandom_range(20, 60)) begin
                @(posedge clk); #1;
                start = ($urandom_range(0, 19) == 0);
                if ($urandom_range(0, 7) == 0) pause = !pause;
                if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
                stop = ($urandom_range(0, 49) == 0);
            end
            @(posedge clk); #1;
            start = 1'b0; pause = 1'b0; stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
        end

        // Asynchronous reset in the middle of a run.
        @(posedge clk); #1;
        seed = 4'b0011; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_led", int'(led), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_tick", int'(step_tick), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ticks0 = n_ticks;
        repeat (12) @(posedge clk);
        #1;
        check("no_tick_after_reset", n_ticks, ticks0);
        check("scoreboard_drained", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
